// File: rtl/vga_fb_pkg.sv
// Shared FSM state encoding and pixel-to-memory mapping helpers for the
// bit-plane framebuffer codec.
package vga_fb_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;
   localparam logic [2:0] ST_CLR  = 3'd5;

   // Word index holding pixel (x,y): columns are contiguous, DATA_WIDTH rows per word
   function automatic int unsigned fb_word(input int unsigned x, input int unsigned y,
                                           input int unsigned mem_h, input int unsigned dw);
      return x + mem_h * (y / dw);
   endfunction

   function automatic int unsigned fb_bit(input int unsigned y, input int unsigned dw);
      return y % dw;
   endfunction

endpackage

// File: rtl/rgb_plane_codec_bit_merge.sv
// Replaces the selected bit of every colour plane in a packed memory word
// with the matching bit of a pixel value.
module bit_merge #(
   parameter int unsigned CHANNELS   = 32'd3,
   parameter int unsigned DATA_WIDTH = 32'd8,
   parameter int unsigned SEL_WIDTH  = 32'd3
)(
   input  logic [CHANNELS*DATA_WIDTH-1:0] word_in,
   input  logic [SEL_WIDTH-1:0]           sel,
   input  logic [CHANNELS-1:0]            pixel,
   output logic [CHANNELS*DATA_WIDTH-1:0] word_out
);

   // Per-plane single-bit replace
   always_comb begin
      word_out = word_in;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         word_out[c*DATA_WIDTH + 32'(sel)] = pixel[c];
      end
   end

endmodule

// File: rtl/rgb_plane_codec.sv
// Bit-plane framebuffer codec: pipelined display readout plus a
// read-modify-write pixel writer and a full-memory clear engine.
module rgb_plane_codec
   import vga_fb_pkg::*;
#(
   parameter int unsigned  CHANNELS   = 32'd3,
   parameter int unsigned  DATA_WIDTH = 32'd8,
   parameter int unsigned  MEM_H      = 32'd80,
   parameter int unsigned  MEM_V      = 32'd60,
   parameter int unsigned  RES_MULT   = 32'd8,
   parameter int unsigned  X_WIDTH    = 32'd10,
   parameter int unsigned  Y_WIDTH    = 32'd10,
   localparam int unsigned WORDS      = MEM_H * ((MEM_V + DATA_WIDTH - 32'd1) / DATA_WIDTH),
   localparam int unsigned ADDR_WIDTH = $clog2(WORDS),
   localparam int unsigned SEL_WIDTH  = $clog2(DATA_WIDTH)
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [X_WIDTH-1:0]             hpos,
   input  logic [Y_WIDTH-1:0]             vpos,
   input  logic                           display_on,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [X_WIDTH-1:0]             wr_x,
   input  logic [Y_WIDTH-1:0]             wr_y,
   input  logic [CHANNELS-1:0]            wr_pixel,
   input  logic                           clear_req,
   output logic                           clear_done,
   output logic                           busy,
   output logic                           oob_err,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic                           mem_we,
   output logic [CHANNELS*DATA_WIDTH-1:0] mem_wdata,
   input  logic [CHANNELS*DATA_WIDTH-1:0] mem_rdata,
   output logic [CHANNELS-1:0]            pix_out
);

   logic [2:0]                     state_r;
   logic [ADDR_WIDTH-1:0]          fsm_addr_r;
   logic [SEL_WIDTH-1:0]           req_bit_r;
   logic [CHANNELS-1:0]            req_pix_r;
   logic                           clear_pend_r;
   logic                           oob_err_r;
   logic                           clear_done_r;
   logic [CHANNELS*DATA_WIDTH-1:0] mem_wdata_r;
   logic [ADDR_WIDTH-1:0]          disp_addr_r;
   logic [SEL_WIDTH-1:0]           disp_bit_d1_r;
   logic [SEL_WIDTH-1:0]           disp_bit_d2_r;
   logic                           disp_on_d1_r;
   logic                           disp_on_d2_r;

   int unsigned                    disp_x_s;
   int unsigned                    disp_y_s;
   logic [ADDR_WIDTH-1:0]          disp_addr_s;
   logic [SEL_WIDTH-1:0]           disp_bit_s;
   logic [ADDR_WIDTH-1:0]          req_word_s;
   logic [SEL_WIDTH-1:0]           req_bit_s;
   logic                           req_oob_s;
   logic                           accept_s;
   logic                           clr_last_s;
   logic [CHANNELS*DATA_WIDTH-1:0] merged_s;

   bit_merge #(
      .CHANNELS   (CHANNELS),
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_bit_merge (
      .word_in  (mem_rdata),
      .sel      (req_bit_r),
      .pixel    (req_pix_r),
      .word_out (merged_s)
   );

   // Screen-to-memory scaling and word/bit mapping for display and write requests
   always_comb begin
      disp_x_s    = 32'(hpos) / RES_MULT;
      disp_y_s    = 32'(vpos) / RES_MULT;
      disp_addr_s = ADDR_WIDTH'(fb_word(disp_x_s, disp_y_s, MEM_H, DATA_WIDTH));
      disp_bit_s  = SEL_WIDTH'(fb_bit(disp_y_s, DATA_WIDTH));
      req_word_s  = ADDR_WIDTH'(fb_word(32'(wr_x), 32'(wr_y), MEM_H, DATA_WIDTH));
      req_bit_s   = SEL_WIDTH'(fb_bit(32'(wr_y), DATA_WIDTH));
      req_oob_s   = (32'(wr_x) >= MEM_H) || (32'(wr_y) >= MEM_V);
      clr_last_s  = (fsm_addr_r == ADDR_WIDTH'(WORDS - 32'd1));
   end

   // A clear request seen this cycle blocks the write handshake so it cannot be lost
   assign wr_ready   = !reset && (state_r == ST_IDLE) && !display_on && !clear_pend_r && !clear_req;
   assign accept_s   = wr_valid && wr_ready;
   assign busy       = (state_r != ST_IDLE);
   assign mem_addr   = display_on ? disp_addr_r : fsm_addr_r;
   assign mem_we     = !reset && !display_on && ((state_r == ST_WR) || (state_r == ST_CLR));
   assign mem_wdata  = mem_wdata_r;
   assign oob_err    = oob_err_r;
   assign clear_done = clear_done_r;

   // Display pipeline: address in N+1, read data and bit select aligned in N+2
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_addr_r   <= {ADDR_WIDTH{1'b0}};
         disp_bit_d1_r <= {SEL_WIDTH{1'b0}};
         disp_bit_d2_r <= {SEL_WIDTH{1'b0}};
         disp_on_d1_r  <= 1'b0;
         disp_on_d2_r  <= 1'b0;
      end else begin
         disp_addr_r   <= disp_addr_s;
         disp_bit_d1_r <= disp_bit_s;
         disp_bit_d2_r <= disp_bit_d1_r;
         disp_on_d1_r  <= display_on;
         disp_on_d2_r  <= disp_on_d1_r;
      end
   end

   // Pick the addressed bit out of each plane of the returned word
   always_comb begin
      pix_out = {CHANNELS{1'b0}};
      if (disp_on_d2_r) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            pix_out[c] = mem_rdata[c*DATA_WIDTH + 32'(disp_bit_d2_r)];
         end
      end else begin
         pix_out = {CHANNELS{1'b0}};
      end
   end

   // Write/clear sequencer; HOLD parks a request whenever the display takes the memory
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         fsm_addr_r   <= {ADDR_WIDTH{1'b0}};
         req_bit_r    <= {SEL_WIDTH{1'b0}};
         req_pix_r    <= {CHANNELS{1'b0}};
         clear_pend_r <= 1'b0;
         oob_err_r    <= 1'b0;
         clear_done_r <= 1'b0;
         mem_wdata_r  <= {(CHANNELS*DATA_WIDTH){1'b0}};
      end else begin
         oob_err_r    <= 1'b0;
         clear_done_r <= 1'b0;
         if (clear_req && (state_r != ST_IDLE) && (state_r != ST_CLR)) begin
            clear_pend_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (clear_req || clear_pend_r) begin
                  state_r      <= ST_CLR;
                  fsm_addr_r   <= {ADDR_WIDTH{1'b0}};
                  mem_wdata_r  <= {(CHANNELS*DATA_WIDTH){1'b0}};
                  clear_pend_r <= 1'b0;
               end else if (accept_s && req_oob_s) begin
                  oob_err_r <= 1'b1;
               end else if (accept_s) begin
                  state_r    <= ST_RD;
                  fsm_addr_r <= req_word_s;
                  req_bit_r  <= req_bit_s;
                  req_pix_r  <= wr_pixel;
               end
            end
            ST_RD:   state_r <= display_on ? ST_HOLD : ST_WAIT;
            ST_WAIT: begin
               if (display_on) begin
                  state_r <= ST_HOLD;
               end else begin
                  mem_wdata_r <= merged_s;
                  state_r     <= ST_WR;
               end
            end
            ST_WR:   state_r <= display_on ? ST_HOLD : ST_IDLE;
            ST_HOLD: state_r <= display_on ? ST_HOLD : ST_RD;
            ST_CLR: begin
               if (!display_on && clr_last_s) begin
                  state_r      <= ST_IDLE;
                  clear_done_r <= 1'b1;
               end else if (!display_on) begin
                  fsm_addr_r <= fsm_addr_r + ADDR_WIDTH'(1);
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_plane_codec.sv
// Self-checking bench for rgb_plane_codec: RAM models, a pixel-level framebuffer
// reference, and directed plus randomized scenarios on default and narrow configs.
module tb_rgb_plane_codec;

   localparam int CH = 3, DW = 8, MH = 80, MV = 60, WORDS = 640;
   localparam int WORDS6 = 800;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, display_on, wr_valid, wr_ready, clear_req, clear_done, busy, oob_err, mem_we;
   logic [9:0] hpos, vpos, wr_x, wr_y, mem_addr;
   logic [2:0] wr_pixel, pix_out;
   logic [23:0] mem_wdata, mem_rdata;

   logic display_on6, wr_valid6, wr_ready6, clear_req6, clear_done6, busy6, oob_err6, mem_we6;
   logic [9:0] hpos6, vpos6, wr_x6, wr_y6, mem_addr6;
   logic [3:0] wr_pixel6, pix_out6;
   logic [23:0] mem_wdata6, mem_rdata6;

   rgb_plane_codec u_dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
      .clear_req(clear_req), .clear_done(clear_done), .busy(busy), .oob_err(oob_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pix_out(pix_out)
   );

   rgb_plane_codec #(.CHANNELS(4), .DATA_WIDTH(6)) u_dut6 (
      .clk(clk), .reset(reset), .hpos(hpos6), .vpos(vpos6), .display_on(display_on6),
      .wr_valid(wr_valid6), .wr_ready(wr_ready6), .wr_x(wr_x6), .wr_y(wr_y6), .wr_pixel(wr_pixel6),
      .clear_req(clear_req6), .clear_done(clear_done6), .busy(busy6), .oob_err(oob_err6),
      .mem_addr(mem_addr6), .mem_we(mem_we6), .mem_wdata(mem_wdata6), .mem_rdata(mem_rdata6),
      .pix_out(pix_out6)
   );

   int checks = 0;
   int errors = 0;

   // Synchronous RAMs (1-cycle read latency) with write logs
   logic [23:0] ram  [0:WORDS-1];
   logic [23:0] ram6 [0:WORDS6-1];
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int log_addr[$];
   logic [23:0] log_data[$];
   int log_cyc[$];
   int log6_addr[$];
   logic [23:0] log6_data[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we && mem_addr < 10'(WORDS)) begin
         ram[mem_addr] <= mem_wdata;
         log_addr.push_back(int'(mem_addr));
         log_data.push_back(mem_wdata);
         log_cyc.push_back(cyc);
      end
      mem_rdata <= (mem_addr < 10'(WORDS)) ? ram[mem_addr] : 24'h000000;
      if (clear_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (mem_we6 && mem_addr6 < 10'(WORDS6)) begin
         ram6[mem_addr6] <= mem_wdata6;
         log6_addr.push_back(int'(mem_addr6));
         log6_data.push_back(mem_wdata6);
      end
      mem_rdata6 <= (mem_addr6 < 10'(WORDS6)) ? ram6[mem_addr6] : 24'h000000;
   end

   // Reference: the picture itself, one RGB value per memory-space pixel (padded rows included)
   logic [2:0] ref_fb [0:MH-1][0:63];
   logic [23:0] ref6 [0:WORDS6-1];

   function automatic logic [23:0] exp_word(input int w);
      logic [23:0] v;
      int x, blk;
      x = w % MH;
      blk = w / MH;
      v = 24'h000000;
      for (int c = 0; c < CH; c++)
         for (int b = 0; b < DW; b++)
            v[c*DW + b] = ref_fb[x][blk*DW + b][c];
      return v;
   endfunction

   task automatic issue_write(input int x, input int y, input logic [2:0] p, output bit ok);
      int n;
      @(posedge clk); #1;
      wr_x = 10'(x); wr_y = 10'(y); wr_pixel = p; wr_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (wr_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      ok = (wr_ready === 1'b1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_log(input int target, input int bound);
      int n;
      n = 0;
      while (log_addr.size() < target && n < bound) begin @(posedge clk); n++; end
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; display_on = 1'b0; wr_valid = 1'b0; clear_req = 1'b0;
      hpos = 10'd0; vpos = 10'd0; wr_x = 10'd0; wr_y = 10'd0; wr_pixel = 3'd0;
      display_on6 = 1'b0; wr_valid6 = 1'b0; clear_req6 = 1'b0;
      hpos6 = 10'd0; vpos6 = 10'd0; wr_x6 = 10'd0; wr_y6 = 10'd0; wr_pixel6 = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
      checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL reset_oob got %b want 0", oob_err); end
      checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", clear_done); end
      checks++; if (pix_out !== 3'd0) begin errors++; $display("FAIL reset_pix got %b want 0", pix_out); end
      checks++; if (mem_wdata !== 24'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
      checks++; if (busy6 !== 1'b0 || mem_we6 !== 1'b0) begin errors++; $display("FAIL reset_narrow got %b%b want 00", busy6, mem_we6); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready got %b want 1", wr_ready); end
   endtask

   task automatic test_write_basic();
      int base;
      bit ok;
      base = log_addr.size();
      issue_write(5, 9, 3'b101, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_handshake got timeout want accept"); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
      ref_fb[5][9] = 3'b101;
      wait_log(base + 1, 20);
      checks++; if (log_addr.size() !== base + 1) begin errors++; $display("FAIL basic_count got %0d want 1", log_addr.size() - base); end
      if (log_addr.size() > base) begin
         checks++; if (log_addr[base] !== 85) begin errors++; $display("FAIL basic_addr got %0d want 85", log_addr[base]); end
         checks++; if (log_data[base] !== 24'hFFFDFF) begin errors++; $display("FAIL basic_data got %h want FFFDFF", log_data[base]); end
         checks++; if (log_data[base] !== exp_word(85)) begin errors++; $display("FAIL basic_model got %h want %h", log_data[base], exp_word(85)); end
      end
   endtask

   task automatic test_display();
      int ea [0:99];
      logic [2:0] ep [0:99];
      int h, v;
      @(posedge clk); #1;
      display_on = 1'b1; hpos = 10'd40; vpos = 10'd72;
      @(posedge clk); #1;
      checks++; if (mem_addr !== 10'd85) begin errors++; $display("FAIL disp_addr got %0d want 85", mem_addr); end
      @(posedge clk); #1;
      checks++; if (pix_out !== ref_fb[5][9]) begin errors++; $display("FAIL disp_pix got %b want %b", pix_out, ref_fb[5][9]); end
      for (int i = 0; i < 100; i++) begin
         h = $urandom_range(0, 639);
         v = $urandom_range(0, 479);
         hpos = 10'(h); vpos = 10'(v);
         ea[i] = h/8 + MH*((v/8)/DW);
         ep[i] = ref_fb[h/8][v/8];
         if (i >= 1) begin
            checks++; if (mem_addr !== 10'(ea[i-1])) begin errors++; $display("FAIL disp_rand_addr got %0d want %0d", mem_addr, ea[i-1]); end
         end
         if (i >= 2) begin
            checks++; if (pix_out !== ep[i-2]) begin errors++; $display("FAIL disp_rand_pix got %b want %b", pix_out, ep[i-2]); end
         end
         @(posedge clk); #1;
      end
      display_on = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pix_out !== 3'd0) begin errors++; $display("FAIL blank_pix got %b want 0", pix_out); end
      @(posedge clk); #1;
      checks++; if (pix_out !== 3'd0) begin errors++; $display("FAIL blank_pix2 got %b want 0", pix_out); end
   endtask

   task automatic test_hold();
      int base, x, y, w;
      logic [2:0] p;
      bit ok;
      for (int d = 0; d < 4; d++) begin
         x = $urandom_range(0, MH-1); y = $urandom_range(0, MV-1); p = 3'($urandom_range(0, 7));
         base = log_addr.size();
         issue_write(x, y, p, ok);
         checks++; if (!ok) begin errors++; $display("FAIL hold_handshake d=%0d got timeout want accept", d); end
         repeat (d) @(posedge clk);
         #0 display_on = 1'b1;
         repeat ($urandom_range(3, 8)) @(posedge clk);
         #1;
         if (d < 3) begin
            checks++; if (log_addr.size() !== base) begin errors++; $display("FAIL hold_nowrite d=%0d got %0d want 0", d, log_addr.size() - base); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy d=%0d got %b want 1", d, busy); end
         end
         display_on = 1'b0;
         ref_fb[x][y] = p;
         w = x + MH*(y/DW);
         wait_log(base + 1, 30);
         checks++; if (log_addr.size() !== base + 1) begin errors++; $display("FAIL hold_count d=%0d got %0d want 1", d, log_addr.size() - base); end
         if (log_addr.size() > base) begin
            checks++; if (log_addr[base] !== w || log_data[base] !== exp_word(w)) begin
               errors++; $display("FAIL hold_data d=%0d got %0d/%h want %0d/%h", d, log_addr[base], log_data[base], w, exp_word(w));
            end
         end
      end
   endtask

   task automatic test_oob();
      int xs [0:2];
      int ys [0:2];
      int base;
      bit ok;
      xs[0] = 80; ys[0] = $urandom_range(0, MV-1);
      xs[1] = $urandom_range(0, MH-1); ys[1] = 60;
      xs[2] = 1023; ys[2] = 1023;
      for (int k = 0; k < 3; k++) begin
         base = log_addr.size();
         issue_write(xs[k], ys[k], 3'b111, ok);
         checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_pulse k=%0d got %b want 1", k, oob_err); end
         checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oob_ready k=%0d got %b want 1", k, wr_ready); end
         @(posedge clk); #1;
         checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL oob_width k=%0d got %b want 0", k, oob_err); end
         repeat (5) @(posedge clk);
         #1;
         checks++; if (log_addr.size() !== base) begin errors++; $display("FAIL oob_nowrite k=%0d got %0d want 0", k, log_addr.size() - base); end
      end
   endtask

   task automatic test_back_to_back();
      int base, n;
      int xs [0:19];
      int ys [0:19];
      int ea [0:19];
      logic [2:0] ps [0:19];
      logic [23:0] ed [0:19];
      base = log_addr.size();
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         xs[k] = $urandom_range(0, MH-1); ys[k] = $urandom_range(0, MV-1); ps[k] = 3'($urandom_range(0, 7));
         if (k % 4 == 3) xs[k] = xs[k-1];
         wr_x = 10'(xs[k]); wr_y = 10'(ys[k]); wr_pixel = ps[k]; wr_valid = 1'b1;
         n = 0;
         @(negedge clk);
         while (wr_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
         checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got timeout want accept", k); end
         @(posedge clk);
         ref_fb[xs[k]][ys[k]] = ps[k];
         ea[k] = xs[k] + MH*(ys[k]/DW);
         ed[k] = exp_word(ea[k]);
         #1;
      end
      wr_valid = 1'b0;
      wait_log(base + 20, 200);
      checks++; if (log_addr.size() !== base + 20) begin errors++; $display("FAIL b2b_count got %0d want 20", log_addr.size() - base); end
      for (int k = 0; k < 20; k++) begin
         if (log_addr.size() > base + k) begin
            checks++; if (log_addr[base+k] !== ea[k] || log_data[base+k] !== ed[k]) begin
               errors++; $display("FAIL b2b_write k=%0d got %0d/%h want %0d/%h", k, log_addr[base+k], log_data[base+k], ea[k], ed[k]);
            end
         end
      end
   endtask

   task automatic test_clear();
      int base, done0, n, x, y, w, bad, last;
      logic [2:0] p;
      bit ok;
      base = log_addr.size();
      done0 = done_cnt;
      x = $urandom_range(0, MH-1); y = $urandom_range(0, MV-1); p = 3'($urandom_range(0, 7));
      issue_write(x, y, p, ok);
      clear_req = 1'b1;
      ref_fb[x][y] = p;
      w = x + MH*(y/DW);
      @(posedge clk); #1;
      clear_req = 1'b0;
      n = 0;
      while (done_cnt == done0 && n < 6000) begin
         display_on = ($urandom_range(0, 3) == 0);
         clear_req = (n == 300);
         @(posedge clk); #1;
         n++;
      end
      display_on = 1'b0; clear_req = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++; if (done_cnt !== done0 + 1) begin errors++; $display("FAIL clear_done_count got %0d want 1", done_cnt - done0); end
      checks++; if (log_addr.size() !== base + 1 + WORDS) begin errors++; $display("FAIL clear_count got %0d want %0d", log_addr.size() - base, 1 + WORDS); end
      if (log_addr.size() >= base + 1 + WORDS) begin
         checks++; if (log_addr[base] !== w || log_data[base] !== exp_word(w)) begin
            errors++; $display("FAIL clear_pending_write got %0d/%h want %0d/%h", log_addr[base], log_data[base], w, exp_word(w));
         end
         bad = 0;
         for (int i = 0; i < WORDS; i++)
            if (log_addr[base+1+i] !== i || log_data[base+1+i] !== 24'd0) bad++;
         checks++; if (bad !== 0) begin errors++; $display("FAIL clear_sequence got %0d bad words want 0", bad); end
         last = log_cyc[base + WORDS];
         checks++; if (done_cyc !== last + 1) begin errors++; $display("FAIL clear_done_time got %0d want %0d", done_cyc, last + 1); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_idle got %b want 0", busy); end
      for (int i = 0; i < MH; i++)
         for (int j = 0; j < 64; j++)
            ref_fb[i][j] = 3'd0;
   endtask

   task automatic test_narrow();
      int xs [0:1];
      int ys [0:1];
      int n, w, b, base;
      logic [3:0] p;
      xs[0] = $urandom_range(0, MH-1); ys[0] = 11;
      xs[1] = $urandom_range(0, MH-1); ys[1] = $urandom_range(0, MV-1);
      for (int k = 0; k < 2; k++) begin
         p = 4'($urandom_range(0, 15));
         base = log6_addr.size();
         @(posedge clk); #1;
         wr_x6 = 10'(xs[k]); wr_y6 = 10'(ys[k]); wr_pixel6 = p; wr_valid6 = 1'b1;
         n = 0;
         @(negedge clk);
         while (wr_ready6 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
         @(posedge clk); #1;
         wr_valid6 = 1'b0;
         w = xs[k] + MH*(ys[k]/6);
         b = ys[k] % 6;
         for (int c = 0; c < 4; c++) ref6[w][c*6 + b] = p[c];
         n = 0;
         while (log6_addr.size() == base && n < 20) begin @(posedge clk); n++; end
         repeat (5) @(posedge clk);
         #1;
         checks++; if (log6_addr.size() !== base + 1) begin errors++; $display("FAIL narrow_count k=%0d got %0d want 1", k, log6_addr.size() - base); end
         if (log6_addr.size() > base) begin
            if (k == 0) begin
               checks++; if (log6_addr[base] !== xs[0] + 80) begin errors++; $display("FAIL narrow_addr got %0d want %0d", log6_addr[base], xs[0] + 80); end
            end
            checks++; if (log6_addr[base] !== w || log6_data[base] !== ref6[w]) begin
               errors++; $display("FAIL narrow_write k=%0d got %0d/%h want %0d/%h", k, log6_addr[base], log6_data[base], w, ref6[w]);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) ram[i] = 24'hFFFFFF;
      for (int i = 0; i < WORDS6; i++) begin ram6[i] = 24'hFFFFFF; ref6[i] = 24'hFFFFFF; end
      for (int i = 0; i < MH; i++)
         for (int j = 0; j < 64; j++)
            ref_fb[i][j] = 3'b111;
      test_reset();
      test_write_basic();
      test_display();
      test_hold();
      test_oob();
      test_back_to_back();
      test_clear();
      test_narrow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
